lif_neuron: RTL and testbench

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/spiking_pkg.sv | 12 +
 rtl/lif_sat_add.sv | 20 ++
 rtl/lif_neuron.sv | 115 +++++++++++
 tb/tb_lif_neuron.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spiking_pkg.sv
// Shared widths and neuron state encoding for the spiking datapath.
package spiking_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int MEM_W_DEF  = 24;

   typedef enum logic {
      ST_INT = 1'b0,
      ST_REF = 1'b1
   } lif_state_t;

endpackage

// File: rtl/lif_sat_add.sv
// Signed saturating adder: the result clamps to the W-bit two's-complement range.
module lif_sat_add #(
   parameter int W = 24
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   logic [W:0] s;
   logic       ovf;

   // One guard bit: overflow occurred exactly when it differs from the sign bit.
   assign s   = {a[W-1], a} + {b[W-1], b};
   assign ovf = s[W] ^ s[W-1];
   assign y   = !ovf ? s[W-1:0]
              : s[W] ? {1'b1, {(W-1){1'b0}}}
              :        {1'b0, {(W-1){1'b1}}};

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: accumulates partial sums per timestep,
// fires on threshold, applies leak and refractory hold-off.
module lif_neuron
   import spiking_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int MEM_W  = MEM_W_DEF,
   parameter int REF_W  = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic [MEM_W-1:0]  cfg_thresh,
   input  logic [3:0]        cfg_leak,
   input  logic [REF_W-1:0]  cfg_refrac,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_spike,
   output logic [MEM_W-1:0]  out_mem,
   output logic [15:0]       spike_cnt
);

   lif_state_t              state, state_nxt;
   logic signed [MEM_W-1:0] mem, mem_nxt, sum, leaked, in_ext;
   logic [REF_W-1:0]        ref_cnt;
   logic                    xfer, close, fire;

   // Holding a result blocks new input, which is what freezes the neuron under backpressure.
   assign in_ready = !out_valid;
   assign xfer     = in_valid && in_ready;
   assign close    = xfer && in_last;
   assign in_ext   = MEM_W'($signed(in_data));

   lif_sat_add #(.W(MEM_W)) u_sat_add (
      .a (mem),
      .b (in_ext),
      .y (sum)
   );

   assign leaked = sum - (sum >>> cfg_leak);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_nxt = state;
      mem_nxt   = mem;
      fire      = 1'b0;
      if (xfer) begin
         if (state == ST_INT) begin
            mem_nxt = sum;
            if (in_last) begin
               fire = (sum >= $signed(cfg_thresh));
               if (fire) begin
                  mem_nxt = '0;
                  if (cfg_refrac != '0)
                     state_nxt = ST_REF;
               end else if (cfg_leak != 4'd0) begin
                  mem_nxt = leaked;
               end
            end
         end else if (in_last && ref_cnt == REF_W'(1)) begin
            state_nxt = ST_INT;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rstn) begin
         state <= ST_INT;
         mem   <= '0;
      end else begin
         state <= state_nxt;
         mem   <= mem_nxt;
      end
   end

   // The refractory counter only moves on timestep close.
   always_ff @(posedge clk) begin
      if (!rstn)
         ref_cnt <= '0;
      else if (close) begin
         if (state == ST_INT) begin
            if (fire)
               ref_cnt <= cfg_refrac;
         end else begin
            ref_cnt <= ref_cnt - REF_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_spike <= 1'b0;
         out_mem   <= '0;
      end else if (close) begin
         out_valid <= 1'b1;
         out_spike <= fire;
         out_mem   <= mem_nxt;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         spike_cnt <= '0;
      else if (close && fire && spike_cnt != 16'hFFFF)
         spike_cnt <= spike_cnt + 16'd1;
   end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: integrate/fire, leak, refractory, saturation,
// backpressure and reset behaviour, all against hand-computed values.
module tb_lif_neuron;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic [23:0] cfg_thresh = '0;
   logic [3:0]  cfg_leak = '0;
   logic [3:0]  cfg_refrac = '0;
   logic        in_ready, out_valid, out_spike;
   logic [23:0] out_mem;
   logic [15:0] spike_cnt;

   logic        r_spk;
   logic [23:0] r_mem;
   logic [15:0] r_cnt;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   lif_neuron #(.DATA_W(16), .MEM_W(24), .REF_W(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .cfg_thresh (cfg_thresh),
      .cfg_leak   (cfg_leak),
      .cfg_refrac (cfg_refrac),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_spike  (out_spike),
      .out_mem    (out_mem),
      .spike_cnt  (spike_cnt)
   );

   // All tasks start and end just after a falling edge.
   task automatic do_reset();
      rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic set_cfg(input int thresh, input int leak, input int refrac);
      cfg_thresh = 24'(thresh);
      cfg_leak   = 4'(leak);
      cfg_refrac = 4'(refrac);
   endtask

   task automatic send_beat(input int d, input bit last);
      int n = 0;
      in_valid = 1'b1; in_data = 16'(d); in_last = last;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         checks++; failures++;
         $display("FAIL beat_timeout in_ready=%b want 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_burst(input int d, input int count);
      for (int i = 0; i < count; i++)
         send_beat(d, i == count - 1);
   endtask

   task automatic get_result();
      int n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (out_valid !== 1'b1) begin
         checks++; failures++;
         $display("FAIL result_timeout out_valid=%b want 1", out_valid);
      end
      r_spk = out_spike; r_mem = out_mem; r_cnt = spike_cnt;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic expect_result(input string name, input logic spk, input logic [23:0] m,
                                input logic [15:0] cnt);
      get_result();
      checks++;
      if (r_spk !== spk || r_mem !== m || r_cnt !== cnt) begin
         failures++;
         $display("FAIL %s got spike=%b mem=%h cnt=%0d want spike=%b mem=%h cnt=%0d",
                  name, r_spk, r_mem, r_cnt, spk, m, cnt);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || out_spike !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got valid=%b spike=%b want 0 0", out_valid, out_spike);
      end
      checks++;
      if (out_mem !== 24'd0 || spike_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_values got mem=%h cnt=%0d want 0 0", out_mem, spike_cnt);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_integrate_fire();
      do_reset();
      set_cfg(100, 0, 0);
      send_beat(40, 1'b0);
      send_beat(40, 1'b0);
      send_beat(30, 1'b1);
      expect_result("fire_110", 1'b1, 24'd0, 16'd1);
      send_beat(99, 1'b1);
      expect_result("below_thresh_99", 1'b0, 24'd99, 16'd1);
      send_beat(1, 1'b1);
      expect_result("equal_thresh_100", 1'b1, 24'd0, 16'd2);
   endtask

   task automatic test_leak();
      set_cfg(100, 1, 0);
      send_beat(60, 1'b1);
      expect_result("leak_60", 1'b0, 24'd30, 16'd2);
      send_beat(50, 1'b1);
      expect_result("leak_80", 1'b0, 24'd40, 16'd2);
      // 40 - 100 = -60; -60 - (-60 >>> 2) = -60 + 15 = -45
      set_cfg(100, 2, 0);
      send_beat(-100, 1'b1);
      expect_result("leak_negative", 1'b0, 24'hFFFFD3, 16'd2);
   endtask

   task automatic test_refractory();
      do_reset();
      set_cfg(100, 0, 2);
      send_beat(150, 1'b1);
      expect_result("ref_fire", 1'b1, 24'd0, 16'd1);
      send_beat(200, 1'b1);
      expect_result("ref_step1", 1'b0, 24'd0, 16'd1);
      send_beat(200, 1'b1);
      expect_result("ref_step2", 1'b0, 24'd0, 16'd1);
      send_beat(200, 1'b1);
      expect_result("ref_refire", 1'b1, 24'd0, 16'd2);
      send_beat(200, 1'b1);
      expect_result("ref_again1", 1'b0, 24'd0, 16'd2);
      send_beat(200, 1'b1);
      expect_result("ref_again2", 1'b0, 24'd0, 16'd2);
      set_cfg(1000, 0, 0);
      send_beat(200, 1'b1);
      expect_result("ref_discarded", 1'b0, 24'd200, 16'd2);
   endtask

   task automatic test_cfg_sampling();
      set_cfg(100, 0, 0);
      send_beat(50, 1'b0);
      set_cfg(1000, 0, 0);
      send_beat(10, 1'b1);
      expect_result("cfg_at_close", 1'b0, 24'd260, 16'd2);
   endtask

   task automatic test_saturation();
      do_reset();
      set_cfg(8388607, 0, 0);
      send_burst(32767, 257);
      expect_result("sat_positive", 1'b1, 24'd0, 16'd1);
      set_cfg(0, 0, 0);
      send_burst(-32768, 257);
      expect_result("sat_negative", 1'b0, 24'h800000, 16'd1);
   endtask

   task automatic test_backpressure();
      do_reset();
      set_cfg(100, 0, 0);
      send_beat(30, 1'b1);
      in_valid = 1'b1; in_data = 16'd50; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_spike !== 1'b0 || out_mem !== 24'd30) begin
            failures++;
            $display("FAIL bp_hold_%0d got rdy=%b valid=%b spike=%b mem=%h want 0 1 0 00001e",
                     i, in_ready, out_valid, out_spike, out_mem);
         end
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got valid=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      send_beat(0, 1'b1);
      expect_result("bp_mem_frozen", 1'b0, 24'd30, 16'd0);
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_cfg(100, 0, 0);
      send_beat(50, 1'b0);
      send_beat(50, 1'b0);
      do_reset();
      send_beat(30, 1'b1);
      expect_result("reset_mid_step", 1'b0, 24'd30, 16'd0);
      set_cfg(100, 0, 3);
      send_beat(150, 1'b1);
      expect_result("reset_ref_fire", 1'b1, 24'd0, 16'd1);
      do_reset();
      send_beat(120, 1'b1);
      expect_result("reset_mid_ref", 1'b1, 24'd0, 16'd1);
      do_reset();
      set_cfg(100, 0, 0);
      send_beat(10, 1'b1);
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || out_mem !== 24'd0) begin
         failures++;
         $display("FAIL reset_pending got valid=%b mem=%h want 0 0", out_valid, out_mem);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_integrate_fire();
      test_leak();
      test_refractory();
      test_cfg_sampling();
      test_saturation();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
